lsu: RTL and testbench
======================

# lsu

Load/store unit between the pipeline MEM stage and the data port of the on-chip RAM. The RAM port is word-wide with a registered, one-cycle read and word-only writes. This block adds:
- byte, halfword and word loads with sign or zero extension;
- byte and halfword stores, done as a read-modify-write sequence;
- address-range and misalignment checks.

Requests use a valid/ready handshake, and each request produces exactly one response pulse.

## Interface
Parameters:
- ADDR_LIMIT, 32'h0001_0000: first byte address outside RAM; any request with addr >= ADDR_LIMIT is an error.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = request rejected, memory untouched.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_ena  out  1  RAM port enable.
- mem_rw  out  1  `MEM_READ` / `MEM_WRITE`.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  RAM read data, valid the cycle after a read-enabled edge.

## Operation
- On accept, latch we, size, unsigned, addr and wdata, and evaluate the error conditions:
  - size==11;
  - addr >= ADDR_LIMIT;
  - misaligned access (see Configuration).
- State machine (state register; all outputs are decoded from state and latched request):
  - IDLE: req_ready=1. On accept go to ERR if in error; to WR for a word store; otherwise to RD.
  - RD: mem_ena=1, mem_rw=READ → CAP.
  - CAP: mem_rdata is valid in this state.
    - Load: extract lane and extend into the result register → RESP.
    - Sub-word store: merge into the store register → WR.
  - WR: mem_ena=1, mem_rw=WRITE, mem_wdata = store register → RESP.
  - RESP: resp_valid=1, resp_err=0 → IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 → IDLE.
- Byte lane selection: lane = addr[1:0], data = word[8*lane+7 : 8*lane]. Halfword: h = addr[1], data = word[16*h+15 : 16*h].
- Extension: bit 7 (byte) or bit 15 (half) is replicated unless req_unsigned is set.
- Merge: the read word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0]. All other bytes are preserved exactly.
- mem_ena = (state==RD || state==WR) && !rst. A reset arriving in the WR cycle suppresses the write.

## Timing
- Accept in cycle T. resp_valid is asserted in:
  - T+1 for errors;
  - T+2 for word stores;
  - T+3 for loads;
  - T+4 for byte/half stores.
- The next request can be accepted at the earliest in the cycle after resp_valid; there is no overlap.
- req_valid deasserting after accept has no effect. Request inputs are ignored outside IDLE.
- Reset values: state IDLE, req_ready=1 (from the cycle after rst), resp_valid=0, resp_err=0, resp_rdata=0, mem_ena=0, mem_rw=READ, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the transaction is abandoned with no response and no further RAM access.
- resp_rdata is held until the next response. resp_err is 0 except in the ERR cycle.

## Configuration
- LSU_MISALIGN_EXC_EN defined:
  - a half with addr[0]=1, or a word with addr[1:0]≠0, goes to ERR;
  - no RAM access is made.
- Not defined:
  - no misalignment error is raised;
  - a word access uses addr[1:0]=00;
  - a half access ignores addr[0] and uses lane h=addr[1].
- The range check and the size==11 check are always active.

## Test plan
- LW addr 0x40, RAM[0x40]=0x8899AABB → resp_valid at T+3, resp_rdata=0x8899AABB, err=0.
- LB addr 0x43 → 0xFFFFFF88. LBU addr 0x43 → 0x00000088. LH addr 0x40 → 0xFFFFAABB. LHU addr 0x42 → 0x00008899.
- SB addr 0x41 wdata 0x12345677 over 0x8899AABB → one read, then one write of 0x889977BB; resp at T+4. A following LW 0x40 returns 0x889977BB.
- SW addr 0x44 wdata 0xDEADBEEF → exactly one mem_ena cycle with mem_rw=WRITE; resp at T+2.
- Error cases, each giving resp_err=1 at T+1 and mem_ena never high:
  - LW addr 0x0001_0000;
  - size=11;
  - with LSU_MISALIGN_EXC_EN, LH addr 0x41.
- Without LSU_MISALIGN_EXC_EN, LW addr 0x42 returns the word at 0x40.
- Assert rst in the WR cycle of an SB → no write reaches the RAM, no resp_valid, req_ready=1 in the next cycle.

Source files
------------

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the pipeline MEM stage and the data port of
// the on-chip RAM. The RAM port is word-wide, reads are registered (data one
// cycle after the enable edge) and writes are whole words only. This unit
// adds sub-word loads with sign/zero extension, sub-word stores done as a
// read-modify-write, and range / size / alignment checks.
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   : a misaligned half or word request is rejected with resp_err.
//   undefined : the low address bits that a half or word does not use are
//               ignored.
//
// Ports:
//   clk, rst          clock (posedge) and synchronous active-high reset
//   req_valid/ready   request handshake; ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend sub-word loads
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_err          request rejected (valid with resp_valid)
//   resp_rdata        extended load data, 0 for stores and errors
//   mem_ena/rw        RAM port enable and direction (0 read, 1 write)
//   mem_addr          word-aligned RAM address
//   mem_wdata         full word written to RAM
//   mem_rdata         RAM read data
// ---------------------------------------------------------------------------
module lsu #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_ena,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] store_q;
   logic [31:0] result_q;

   logic        misalign;
   logic        req_bad;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Alignment check on the incoming request; without the feature the unused
   // low address bits are simply ignored further down.
`ifdef LSU_MISALIGN_EXC_EN
   assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_bad = (req_size == 2'b11) || (req_addr >= ADDR_LIMIT) || misalign;

   // Lane extraction and extension of the returned word for loads, and the
   // read-modify-write merge for sub-word stores. Both only matter in CAP,
   // when mem_rdata holds the word read in RD.
   always_comb begin
      byte_val = 8'h00;
      case (addr_q[1:0])
         2'd0:    byte_val = mem_rdata[7:0];
         2'd1:    byte_val = mem_rdata[15:8];
         2'd2:    byte_val = mem_rdata[23:16];
         default: byte_val = mem_rdata[31:24];
      endcase
      half_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      load_val = mem_rdata;
      if (size_q == SZ_BYTE) begin
         load_val = uns_q ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
      end else if (size_q == SZ_HALF) begin
         load_val = uns_q ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
      end

      merged = mem_rdata;
      if (size_q == SZ_BYTE) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = store_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = store_q[15:0];
      end
   end

   // Main sequencer. The request is latched on accept; the result register
   // only changes when a response is produced, so resp_rdata holds the last
   // response value in between.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         uns_q    <= 1'b0;
         addr_q   <= 32'h0;
         store_q  <= 32'h0;
         result_q <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  store_q <= req_wdata;
                  if (req_bad) begin
                     result_q <= 32'h0;
                     state    <= S_ERR;
                  end else if (req_we && (req_size == SZ_WORD)) begin
                     state <= S_WR;
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_RD: begin
               state <= S_CAP;
            end
            S_CAP: begin
               if (we_q) begin
                  store_q <= merged;
                  state   <= S_WR;
               end else begin
                  result_q <= load_val;
                  state    <= S_RESP;
               end
            end
            S_WR: begin
               result_q <= 32'h0;
               state    <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state and the latched request. The enable is
   // gated by rst so a reset landing in the WR cycle suppresses the write.
   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP) || (state == S_ERR);
   assign resp_err   = (state == S_ERR);
   assign resp_rdata = result_q;
   assign mem_ena    = ((state == S_RD) || (state == S_WR)) && !rst;
   assign mem_rw     = (state == S_WR) ? MEM_WRITE : MEM_READ;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = store_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed self-checking bench for lsu with a small registered RAM
// model attached to the memory port. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_ena;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ram [0:255];
   int          ena_count   = 0;
   int          write_count = 0;
   logic [31:0] last_waddr  = 32'h0;
   logic [31:0] last_wdata  = 32'h0;
   logic        preload_en;
   logic [7:0]  preload_idx;
   logic [31:0] preload_data;

   always #5 clk = ~clk;

   lsu dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_ena      (mem_ena),
      .mem_rw       (mem_rw),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // Registered-read RAM with a side preload port and access counters.
   always @(posedge clk) begin
      if (preload_en) begin
         ram[preload_idx] <= preload_data;
      end
      if (mem_ena) begin
         ena_count <= ena_count + 1;
         if (mem_rw) begin
            ram[mem_addr[9:2]] <= mem_wdata;
            write_count        <= write_count + 1;
            last_waddr         <= mem_addr;
            last_wdata         <= mem_wdata;
         end else begin
            mem_rdata <= ram[mem_addr[9:2]];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issues one request, waits (bounded) for the response and reports the
   // latency in cycles after accept plus the RAM traffic it caused.
   task automatic applyStimulus(input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output int lat, output logic [31:0] rdata,
                                output logic err, output int enas,
                                output int writes);
      int e0;
      int w0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      e0 = ena_count;
      w0 = write_count;
      @(posedge clk);
      @(negedge clk);
      req_valid    = 1'b0;
      req_addr     = 32'hFFFF_FFFC;
      req_size     = 2'b11;
      req_wdata    = 32'h5A5A_5A5A;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) lat = 99;
      rdata  = resp_rdata;
      err    = resp_err;
      enas   = ena_count - e0;
      writes = write_count - w0;
   endtask

   task automatic runCheck(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_enas, input int exp_writes);
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          enas;
      int          writes;
      applyStimulus(we, size, uns, addr, wdata, lat, rdata, err, enas, writes);
      checkOutput({tag, "_lat"}, lat, exp_lat);
      checkOutput({tag, "_rdata"}, rdata, exp_rdata);
      checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
      checkOutput({tag, "_enas"}, enas, exp_enas);
      checkOutput({tag, "_writes"}, writes, exp_writes);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      preload_en   = 1'b0;
      preload_idx  = 8'h0;
      preload_data = 32'h0;

      // Preload RAM while in reset.
      @(negedge clk);
      preload_en   = 1'b1;
      preload_idx  = 8'h10;
      preload_data = 32'h8899_AABB;
      @(negedge clk);
      preload_idx  = 8'hFF;
      preload_data = 32'h0123_4567;
      @(negedge clk);
      preload_en   = 1'b0;
      checkOutput("rst_mem_ena_in_reset", {31'h0, mem_ena}, 32'h0);
      rst = 1'b0;

      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_mem_ena", {31'h0, mem_ena}, 32'h0);
      checkOutput("rst_mem_rw", {31'h0, mem_rw}, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);

      // Loads of every size and extension.
      runCheck("lw_40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'h8899_AABB, 1'b0, 1, 0);
      runCheck("lb_43",  1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 3, 32'hFFFF_FF88, 1'b0, 1, 0);
      runCheck("lbu_43", 1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 3, 32'h0000_0088, 1'b0, 1, 0);
      runCheck("lb_41",  1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 3, 32'hFFFF_FFAA, 1'b0, 1, 0);
      runCheck("lbu_40", 1'b0, 2'b00, 1'b1, 32'h40, 32'h0, 3, 32'h0000_00BB, 1'b0, 1, 0);
      runCheck("lh_40",  1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 3, 32'hFFFF_AABB, 1'b0, 1, 0);
      runCheck("lhu_42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 3, 32'h0000_8899, 1'b0, 1, 0);
      runCheck("lh_42",  1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 3, 32'hFFFF_8899, 1'b0, 1, 0);

      // Sub-word stores via read-modify-write.
      runCheck("sb_41", 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_5677, 4, 32'h0, 1'b0, 2, 1);
      checkOutput("sb_41_waddr", last_waddr, 32'h40);
      checkOutput("sb_41_wdata", last_wdata, 32'h8899_77BB);
      runCheck("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'h8899_77BB, 1'b0, 1, 0);
      runCheck("sh_42", 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_CAFE, 4, 32'h0, 1'b0, 2, 1);
      checkOutput("sh_42_wdata", last_wdata, 32'hCAFE_77BB);
      runCheck("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, 32'hCAFE_77BB, 1'b0, 1, 0);

      // Word store and readback, then check the response data is held.
      runCheck("sw_44", 1'b1, 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 1);
      checkOutput("sw_44_waddr", last_waddr, 32'h44);
      checkOutput("sw_44_wdata", last_wdata, 32'hDEAD_BEEF);
      runCheck("lw_44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);
      @(negedge clk);
      checkOutput("hold_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("hold_resp_err", {31'h0, resp_err}, 32'h0);
      checkOutput("hold_resp_rdata", resp_rdata, 32'hDEAD_BEEF);

      // Error cases and the last in-range word.
      runCheck("err_range", 1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      runCheck("err_size",  1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      runCheck("err_sw_hi", 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1, 1, 32'h0, 1'b1, 0, 0);
      runCheck("lw_fffc",   1'b0, 2'b10, 1'b0, 32'h0000_FFFC, 32'h0, 3, 32'h0123_4567, 1'b0, 1, 0);

      // Misaligned accesses.
`ifdef LSU_MISALIGN_EXC_EN
      runCheck("mis_lh_41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      runCheck("mis_lw_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1, 32'h0, 1'b1, 0, 0);
`else
      runCheck("mis_lw_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 3, 32'hCAFE_77BB, 1'b0, 1, 0);
      runCheck("mis_lh_41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 3, 32'h0000_77BB, 1'b0, 1, 0);
      runCheck("mis_lh_43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 3, 32'hFFFF_CAFE, 1'b0, 1, 0);
`endif

      // Reset during the WR cycle of a byte store.
      begin
         int w0;
         int lat;
         int enas;
         int writes;
         logic [31:0] rdata;
         logic        err;
         @(negedge clk);
         req_valid    = 1'b1;
         req_we       = 1'b1;
         req_size     = 2'b00;
         req_unsigned = 1'b0;
         req_addr     = 32'h41;
         req_wdata    = 32'h0000_00AB;
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         checkOutput("rstwr_ena_before", {31'h0, mem_ena}, 32'h1);
         checkOutput("rstwr_rw_before", {31'h0, mem_rw}, 32'h1);
         checkOutput("rstwr_wdata_before", mem_wdata, 32'hCAFE_ABBB);
         w0  = write_count;
         rst = 1'b1;
         #1;
         checkOutput("rstwr_ena_gated", {31'h0, mem_ena}, 32'h0);
         @(posedge clk);
         @(negedge clk);
         checkOutput("rstwr_no_write", write_count - w0, 32'h0);
         checkOutput("rstwr_resp_valid", {31'h0, resp_valid}, 32'h0);
         checkOutput("rstwr_req_ready", {31'h0, req_ready}, 32'h1);
         rst = 1'b0;
         applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rdata, err, enas, writes);
         checkOutput("rstwr_readback_lat", lat, 3);
         checkOutput("rstwr_readback", rdata, 32'hCAFE_77BB);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
